// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_queue (plus instr_queue_pkg)
// Purpose  : In-order instruction FIFO between fetch and issue. Applies
//            back-pressure through iq_full. A branch-redirect flush discards
//            every buffered entry. A sticky error flag records any enqueue
//            attempted while full and any dequeue attempted while empty.
// Ports    : clk          - system clock, rising edge
//            rst_n        - synchronous active-low reset
//            iq_enq       - enqueue request from fetch
//            iq_enq_data  - entry to store (inst, pc, order, valid)
//            iq_full      - queue holds DEPTH entries
//            iq_deq       - issue pops the head entry this cycle
//            iq_deq_data  - current head entry (valid gated by ~empty)
//            iq_empty     - queue holds 0 entries
//            iq_flush     - discard all entries
//            iq_count     - occupancy, 0..DEPTH
//            iq_err       - sticky overflow/underflow attempt flag
// Revision : 1.0 - initial release
// ============================================================================

package instr_queue_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
    logic        valid;
  } iq_entry_t;
endpackage

module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 8   // power of 2, >= 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iq_enq,
  input  iq_entry_t                iq_enq_data,
  output logic                     iq_full,
  input  logic                     iq_deq,
  output iq_entry_t                iq_deq_data,
  output logic                     iq_empty,
  input  logic                     iq_flush,
  output logic [$clog2(DEPTH):0]   iq_count,
  output logic                     iq_err
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  iq_entry_t            r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_head;
  logic [c_ptr_w-1:0]   r_tail;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_err;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_enq_ok;
  logic                 w_deq_ok;
  iq_entry_t            w_head_entry;

  // Full/empty come from the registered count only, so fetch may build its
  // enqueue request combinationally from iq_full without forming a loop.
  assign w_full   = (r_count == c_cnt_w'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_enq_ok = iq_enq & ~w_full;
  assign w_deq_ok = iq_deq & ~w_empty;

  // Storage is not reset; only the pointers and count define occupancy.
  // A flush suppresses the write so a lost enqueue never lands in the array.
  always_ff @(posedge clk) begin
    if (rst_n && !iq_flush && w_enq_ok) begin
      r_mem[r_tail] <= iq_enq_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (iq_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_ok) begin
        r_tail <= r_tail + c_ptr_w'(1);
      end
      if (w_deq_ok) begin
        r_head <= r_head + c_ptr_w'(1);
      end
      case ({w_enq_ok, w_deq_ok})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if ((iq_enq && w_full) || (iq_deq && w_empty)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_head_entry = r_mem[r_head];

  always_comb begin
    iq_deq_data       = w_head_entry;
    // Stale array contents must never look like a live entry.
    iq_deq_data.valid = w_head_entry.valid & ~w_empty;
  end

  assign iq_full  = w_full;
  assign iq_empty = w_empty;
  assign iq_count = r_count;
  assign iq_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_queue
// Purpose  : Directed and randomized self-checking bench for instr_queue
//            (DEPTH = 8).
// Revision : 1.0 - initial release
// ============================================================================

module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enq;
  iq_entry_t  enq_data;
  logic       full;
  logic       deq;
  iq_entry_t  deq_data;
  logic       empty;
  logic       flush;
  logic [3:0] count;
  logic       err;

  int errors = 0;
  int checks = 0;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iq_enq      (enq),
    .iq_enq_data (enq_data),
    .iq_full     (full),
    .iq_deq      (deq),
    .iq_deq_data (deq_data),
    .iq_empty    (empty),
    .iq_flush    (flush),
    .iq_count    (count),
    .iq_err      (err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic iq_entry_t mk(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [63:0] order);
    iq_entry_t e;
    e.inst  = inst;
    e.pc    = pc;
    e.order = order;
    e.valid = 1'b1;
    return e;
  endfunction

  task automatic idle();
    enq = 1'b0; deq = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; idle(); enq = 1'b1;
    tick(); tick();
    rst_n = 1'b1; idle();
  endtask

  task automatic push(input iq_entry_t e);
    enq = 1'b1; enq_data = e;
    tick();
    enq = 1'b0;
  endtask

  task automatic test_reset();
    enq_data = mk(32'h1, 32'h2, 64'h3);
    do_reset();
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 ||
        deq_data.valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d empty=%b full=%b valid=%b err=%b, want 0 1 0 0 0",
               count, empty, full, deq_data.valid, err);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int k = 0; k < 8; k++) push(mk(32'h100 + k, 32'h60000000 + 4 * k, 64'(k)));
    checks++;
    if (full !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d, want 1 8", full, count);
    end
    push(mk(32'hBAD, 32'h600000F0, 64'd99));
    checks++;
    if (full !== 1'b1 || count !== 4'd8 || err !== 1'b1) begin
      errors++;
      $display("FAIL overflow: full=%b count=%0d err=%b, want 1 8 1", full, count, err);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (deq_data.pc !== 32'h60000000 + 4 * k || deq_data.order !== 64'(k) ||
          deq_data.inst !== 32'h100 + k || deq_data.valid !== 1'b1) begin
        errors++;
        $display("FAIL drain[%0d]: pc=%h order=%0d valid=%b, want pc=%h order=%0d valid=1",
                 k, deq_data.pc, deq_data.order, deq_data.valid, 32'h60000000 + 4 * k, k);
      end
      deq = 1'b1; tick(); deq = 1'b0;
    end
    checks++;
    if (empty !== 1'b1 || count !== 4'd0 || deq_data.valid !== 1'b0) begin
      errors++;
      $display("FAIL drained: empty=%b count=%0d valid=%b, want 1 0 0",
               empty, count, deq_data.valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 3; k++) push(mk(32'h0, 32'h70000000 + 4 * k, 64'(k)));
    for (int j = 0; j < 20; j++) begin
      checks++;
      if (count !== 4'd3 || deq_data.pc !== 32'h70000000 + 4 * j || deq_data.valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: count=%0d pc=%h, want 3 %h", j, count, deq_data.pc,
                 32'h70000000 + 4 * j);
      end
      enq = 1'b1; deq = 1'b1;
      enq_data = mk(32'h0, 32'h70000000 + 4 * (j + 3), 64'(j + 3));
      tick();
    end
    idle();
    checks++;
    if (count !== 4'd3 || deq_data.pc !== 32'h70000000 + 4 * 20) begin
      errors++;
      $display("FAIL b2b end: count=%0d pc=%h, want 3 %h", count, deq_data.pc,
               32'h70000000 + 4 * 20);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int k = 0; k < 8; k++) push(mk(32'h0, 32'h80000000 + 4 * k, 64'(k)));
    enq = 1'b1; deq = 1'b1; enq_data = mk(32'h0, 32'hDEADBEE0, 64'd77);
    tick();
    idle();
    checks++;
    if (count !== 4'd7 || full !== 1'b0 || deq_data.pc !== 32'h80000004) begin
      errors++;
      $display("FAIL full simul: count=%0d full=%b pc=%h, want 7 0 80000004",
               count, full, deq_data.pc);
    end
    for (int k = 1; k < 8; k++) begin
      checks++;
      if (deq_data.pc !== 32'h80000000 + 4 * k) begin
        errors++;
        $display("FAIL full simul drain[%0d]: pc=%h want %h", k, deq_data.pc,
                 32'h80000000 + 4 * k);
      end
      deq = 1'b1; tick(); deq = 1'b0;
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL full simul empty: empty=%b want 1", empty);
    end
  endtask

  task automatic test_empty_edge();
    do_reset();
    enq = 1'b1; deq = 1'b1; enq_data = mk(32'h00000013, 32'h60000040, 64'd5);
    tick();
    idle();
    checks++;
    if (err !== 1'b1 || count !== 4'd1 || deq_data.inst !== 32'h00000013 ||
        deq_data.valid !== 1'b1) begin
      errors++;
      $display("FAIL empty edge: err=%b count=%0d inst=%h valid=%b, want 1 1 00000013 1",
               err, count, deq_data.inst, deq_data.valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 5; k++) push(mk(32'h0, 32'h90000000 + 4 * k, 64'(k)));
    flush = 1'b1; enq = 1'b1; deq = 1'b1; enq_data = mk(32'h0, 32'hDEAD0000, 64'd55);
    tick();
    idle();
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || deq_data.valid !== 1'b0 ||
        err !== 1'b0) begin
      errors++;
      $display("FAIL flush: count=%0d empty=%b full=%b valid=%b err=%b, want 0 1 0 0 0",
               count, empty, full, deq_data.valid, err);
    end
    push(mk(32'h0, 32'h60000100, 64'd6));
    checks++;
    if (count !== 4'd1 || deq_data.pc !== 32'h60000100 || deq_data.valid !== 1'b1) begin
      errors++;
      $display("FAIL post flush: count=%0d pc=%h valid=%b, want 1 60000100 1",
               count, deq_data.pc, deq_data.valid);
    end
  endtask

  task automatic test_soak();
    iq_entry_t model[$];
    logic m_err;
    logic e, d, f, eok, dok;
    iq_entry_t nd;
    do_reset();
    m_err = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      checks++;
      if (count !== 4'(model.size()) || full !== (model.size() == DEPTH) ||
          empty !== (model.size() == 0) || err !== m_err) begin
        errors++;
        $display("FAIL soak state @%0d: count=%0d full=%b empty=%b err=%b, want count=%0d err=%b",
                 c, count, full, empty, err, model.size(), m_err);
      end
      checks++;
      if (model.size() > 0) begin
        if (deq_data !== model[0]) begin
          errors++;
          $display("FAIL soak data @%0d: got %h want %h", c, deq_data, model[0]);
        end
      end else if (deq_data.valid !== 1'b0) begin
        errors++;
        $display("FAIL soak empty valid @%0d: valid=%b want 0", c, deq_data.valid);
      end
      e = ($urandom_range(0, 99) < 55);
      d = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 63) == 0);
      nd.inst = $urandom; nd.pc = $urandom; nd.order = {$urandom, $urandom};
      nd.valid = ($urandom_range(0, 7) != 0);
      enq = e; deq = d; flush = f; enq_data = nd;
      if (f) begin
        model.delete();
      end else begin
        eok = e && (model.size() < DEPTH);
        dok = d && (model.size() > 0);
        if ((e && !eok) || (d && !dok)) m_err = 1'b1;
        if (dok) void'(model.pop_front());
        if (eok) model.push_back(nd);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    enq_data = '0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_simul();
    test_empty_edge();
    test_flush();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
